// File: rtl/wt_dcache_rd_arb.sv
// Round-robin arbiter between the dcache read controllers and the single dcache memory read port.
// Grants one read per cycle, steers the late tag one cycle after grant and routes the hit vector to the last winner.
module wt_dcache_rd_arb #(
    parameter  int NumPorts = 3,
    parameter  int IdxW     = 8,
    parameter  int OffW     = 4,
    parameter  int TagW     = 20,
    parameter  int SetAssoc = 4,
    localparam int SelW     = $clog2(NumPorts)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 rd_req_i,
    input  logic [NumPorts-1:0]                 rd_tag_only_i,
    input  logic [NumPorts-1:0][IdxW-1:0]       rd_idx_i,
    input  logic [NumPorts-1:0][OffW-1:0]       rd_off_i,
    input  logic [NumPorts-1:0][TagW-1:0]       rd_tag_i,
    output logic [NumPorts-1:0]                 rd_ack_o,
    output logic [63:0]                         rd_data_o,
    output logic [SetAssoc-1:0]                 rd_vld_bits_o,
    output logic [NumPorts-1:0][SetAssoc-1:0]   rd_hit_oh_o,
    output logic                                mem_rd_req_o,
    output logic                                mem_rd_tag_only_o,
    output logic [IdxW-1:0]                     mem_rd_idx_o,
    output logic [OffW-1:0]                     mem_rd_off_o,
    output logic [TagW-1:0]                     mem_rd_tag_o,
    input  logic                                mem_rd_ack_i,
    input  logic [63:0]                         mem_rd_data_i,
    input  logic [SetAssoc-1:0]                 mem_rd_vld_bits_i,
    input  logic [SetAssoc-1:0]                 mem_rd_hit_oh_i
);

    if (NumPorts < 2) begin : g_bad_numports
        $error("wt_dcache_rd_arb: NumPorts must be at least 2");
    end

    logic [SelW-1:0] r_rr;
    logic [SelW-1:0] r_sel;
    logic            r_gnt_vld;

    logic [SelW-1:0] w_win;
    logic [SelW-1:0] w_hi_win;
    logic [SelW-1:0] w_lo_win;
    logic            w_hi_found;
    logic            w_lo_found;
    logic            w_any;
    logic            w_accept;
    logic [SelW-1:0] w_next_rr;

    // Winner: lowest requester at or above the pointer, else wrap to the lowest requester overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_win   = '0;
        w_lo_win   = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (rd_req_i[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_win   = SelW'(i);
            end
            if (rd_req_i[i] && (SelW'(i) >= r_rr) && !w_hi_found) begin
                w_hi_found = 1'b1;
                w_hi_win   = SelW'(i);
            end
        end
        w_win = w_hi_found ? w_hi_win : w_lo_win;
    end

    assign w_any     = |rd_req_i;
    assign w_accept  = mem_rd_ack_i & w_any;
    assign w_next_rr = (w_win == SelW'(NumPorts - 1)) ? '0 : w_win + SelW'(1);

    always_comb begin
        rd_ack_o        = '0;
        rd_ack_o[w_win] = w_accept;
    end

    assign mem_rd_req_o      = w_any;
    assign mem_rd_tag_only_o = rd_tag_only_i[w_win];
    assign mem_rd_idx_o      = rd_idx_i[w_win];
    assign mem_rd_off_o      = rd_off_i[w_win];
    // The controller only presents its tag the cycle after grant, so the registered select drives it.
    assign mem_rd_tag_o      = rd_tag_i[r_sel];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr      <= '0;
            r_sel     <= '0;
            r_gnt_vld <= 1'b0;
        end else begin
            r_gnt_vld <= w_accept;
            if (w_accept) begin
                r_rr  <= w_next_rr;
                r_sel <= w_win;
            end
        end
    end

    assign rd_data_o     = mem_rd_data_i;
    assign rd_vld_bits_o = mem_rd_vld_bits_i;

    always_comb begin
        rd_hit_oh_o = '0;
        if (r_gnt_vld) begin
            rd_hit_oh_o[r_sel] = mem_rd_hit_oh_i;
        end
    end

    a_ack_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rd_ack_o));

    a_hit_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_gnt_vld |-> $onehot0(mem_rd_hit_oh_i));

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Directed bench for wt_dcache_rd_arb: grant order, tag steering, hit gating, stalls and async reset.
module tb_wt_dcache_rd_arb;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [2:0]           rd_req_i;
    logic [2:0]           rd_tag_only_i;
    logic [2:0][7:0]      rd_idx_i;
    logic [2:0][3:0]      rd_off_i;
    logic [2:0][19:0]     rd_tag_i;
    logic [2:0]           rd_ack_o;
    logic [63:0]          rd_data_o;
    logic [3:0]           rd_vld_bits_o;
    logic [2:0][3:0]      rd_hit_oh_o;
    logic                 mem_rd_req_o;
    logic                 mem_rd_tag_only_o;
    logic [7:0]           mem_rd_idx_o;
    logic [3:0]           mem_rd_off_o;
    logic [19:0]          mem_rd_tag_o;
    logic                 mem_rd_ack_i;
    logic [63:0]          mem_rd_data_i;
    logic [3:0]           mem_rd_vld_bits_i;
    logic [3:0]           mem_rd_hit_oh_i;

    int checks = 0;
    int errors = 0;

    wt_dcache_rd_arb #(
        .NumPorts (3),
        .IdxW     (8),
        .OffW     (4),
        .TagW     (20),
        .SetAssoc (4)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .rd_req_i          (rd_req_i),
        .rd_tag_only_i     (rd_tag_only_i),
        .rd_idx_i          (rd_idx_i),
        .rd_off_i          (rd_off_i),
        .rd_tag_i          (rd_tag_i),
        .rd_ack_o          (rd_ack_o),
        .rd_data_o         (rd_data_o),
        .rd_vld_bits_o     (rd_vld_bits_o),
        .rd_hit_oh_o       (rd_hit_oh_o),
        .mem_rd_req_o      (mem_rd_req_o),
        .mem_rd_tag_only_o (mem_rd_tag_only_o),
        .mem_rd_idx_o      (mem_rd_idx_o),
        .mem_rd_off_o      (mem_rd_off_o),
        .mem_rd_tag_o      (mem_rd_tag_o),
        .mem_rd_ack_i      (mem_rd_ack_i),
        .mem_rd_data_i     (mem_rd_data_i),
        .mem_rd_vld_bits_i (mem_rd_vld_bits_i),
        .mem_rd_hit_oh_i   (mem_rd_hit_oh_i)
    );

    always #5 clk_i = ~clk_i;

    // Port fields: idx 30/41/52, off 3/5/9, tag AAAA0/BBBB1/CCCC2, only port 2 is tag-only.
    task automatic test_reset();
        rst_ni            = 1'b0;
        rd_req_i          = 3'b000;
        rd_tag_only_i     = 3'b100;
        rd_idx_i          = {8'h52, 8'h41, 8'h30};
        rd_off_i          = {4'h9, 4'h5, 4'h3};
        rd_tag_i          = {20'hCCCC2, 20'hBBBB1, 20'hAAAA0};
        mem_rd_ack_i      = 1'b1;
        mem_rd_data_i     = 64'h0;
        mem_rd_vld_bits_i = 4'h0;
        mem_rd_hit_oh_i   = 4'b0010;
        #12;
        checks++; if (rd_ack_o !== 3'b000) begin errors++; $display("FAIL reset_ack got %b exp %b", rd_ack_o, 3'b000); end
        checks++; if (rd_hit_oh_o !== 12'h000) begin errors++; $display("FAIL reset_hit got %h exp %h", rd_hit_oh_o, 12'h000); end
        checks++; if (mem_rd_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp %b", mem_rd_req_o, 1'b0); end
        checks++; if (mem_rd_tag_o !== 20'hAAAA0) begin errors++; $display("FAIL reset_tag got %h exp %h", mem_rd_tag_o, 20'hAAAA0); end
        #5 rst_ni = 1'b1;
    endtask

    task automatic test_fairness();
        logic [2:0]  exp_ack [6];
        logic [19:0] exp_tag [6];
        logic [7:0]  exp_idx [6];
        exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_idx = '{8'h30, 8'h41, 8'h52, 8'h30, 8'h41, 8'h52};
        exp_tag = '{20'hAAAA0, 20'hAAAA0, 20'hBBBB1, 20'hCCCC2, 20'hAAAA0, 20'hBBBB1};
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            rd_req_i     = 3'b111;
            mem_rd_ack_i = 1'b1;
            #1;
            checks++; if (rd_ack_o !== exp_ack[c]) begin errors++; $display("FAIL fair_ack[%0d] got %b exp %b", c, rd_ack_o, exp_ack[c]); end
            checks++; if (mem_rd_idx_o !== exp_idx[c]) begin errors++; $display("FAIL fair_idx[%0d] got %h exp %h", c, mem_rd_idx_o, exp_idx[c]); end
            if (c > 0) begin
                checks++; if (mem_rd_tag_o !== exp_tag[c]) begin errors++; $display("FAIL fair_tag[%0d] got %h exp %h", c, mem_rd_tag_o, exp_tag[c]); end
            end
        end
    endtask

    task automatic test_single();
        @(posedge clk_i); #1;
        rd_req_i = 3'b010;
        #1;
        checks++; if (rd_ack_o !== 3'b010) begin errors++; $display("FAIL single_ack got %b exp %b", rd_ack_o, 3'b010); end
        checks++; if (mem_rd_off_o !== 4'h5) begin errors++; $display("FAIL single_off got %h exp %h", mem_rd_off_o, 4'h5); end
        checks++; if (mem_rd_tag_only_o !== 1'b0) begin errors++; $display("FAIL single_tag_only got %b exp %b", mem_rd_tag_only_o, 1'b0); end
        @(posedge clk_i); #1;
        rd_req_i          = 3'b000;
        mem_rd_data_i     = 64'hDEAD_BEEF_0123_4567;
        mem_rd_vld_bits_i = 4'b1011;
        mem_rd_hit_oh_i   = 4'b0100;
        #1;
        checks++; if (mem_rd_tag_o !== 20'hBBBB1) begin errors++; $display("FAIL single_tag got %h exp %h", mem_rd_tag_o, 20'hBBBB1); end
        checks++; if (rd_hit_oh_o !== 12'h040) begin errors++; $display("FAIL single_hit got %h exp %h", rd_hit_oh_o, 12'h040); end
        checks++; if (rd_data_o !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL single_data got %h exp %h", rd_data_o, 64'hDEAD_BEEF_0123_4567); end
        checks++; if (rd_vld_bits_o !== 4'b1011) begin errors++; $display("FAIL single_vld got %b exp %b", rd_vld_bits_o, 4'b1011); end
        checks++; if (rd_ack_o !== 3'b000) begin errors++; $display("FAIL single_noreq_ack got %b exp %b", rd_ack_o, 3'b000); end
        checks++; if (mem_rd_req_o !== 1'b0) begin errors++; $display("FAIL single_noreq_req got %b exp %b", mem_rd_req_o, 1'b0); end
    endtask

    task automatic test_mem_busy();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            rd_req_i        = 3'b101;
            mem_rd_ack_i    = 1'b0;
            mem_rd_hit_oh_i = 4'b0010;
            #1;
            checks++; if (rd_ack_o !== 3'b000) begin errors++; $display("FAIL busy_ack[%0d] got %b exp %b", c, rd_ack_o, 3'b000); end
            checks++; if (rd_hit_oh_o !== 12'h000) begin errors++; $display("FAIL busy_hit[%0d] got %h exp %h", c, rd_hit_oh_o, 12'h000); end
            checks++; if (mem_rd_idx_o !== 8'h52) begin errors++; $display("FAIL busy_idx[%0d] got %h exp %h", c, mem_rd_idx_o, 8'h52); end
            checks++; if (mem_rd_req_o !== 1'b1) begin errors++; $display("FAIL busy_req[%0d] got %b exp %b", c, mem_rd_req_o, 1'b1); end
        end
        @(posedge clk_i); #1;
        mem_rd_ack_i = 1'b1;
        #1;
        checks++; if (rd_ack_o !== 3'b100) begin errors++; $display("FAIL busy_release_ack got %b exp %b", rd_ack_o, 3'b100); end
        checks++; if (mem_rd_tag_only_o !== 1'b1) begin errors++; $display("FAIL busy_tag_only got %b exp %b", mem_rd_tag_only_o, 1'b1); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk_i); #1;
        rd_req_i        = 3'b101;
        mem_rd_hit_oh_i = 4'b0001;
        #1;
        checks++; if (rd_ack_o !== 3'b001) begin errors++; $display("FAIL b2b_wrap_ack got %b exp %b", rd_ack_o, 3'b001); end
        checks++; if (rd_hit_oh_o !== 12'h100) begin errors++; $display("FAIL b2b_hit_p2a got %h exp %h", rd_hit_oh_o, 12'h100); end
        checks++; if (mem_rd_tag_o !== 20'hCCCC2) begin errors++; $display("FAIL b2b_tag_p2a got %h exp %h", mem_rd_tag_o, 20'hCCCC2); end
        @(posedge clk_i); #1;
        rd_req_i        = 3'b100;
        mem_rd_hit_oh_i = 4'b1000;
        #1;
        checks++; if (rd_ack_o !== 3'b100) begin errors++; $display("FAIL b2b_ack_p2 got %b exp %b", rd_ack_o, 3'b100); end
        checks++; if (rd_hit_oh_o !== 12'h008) begin errors++; $display("FAIL b2b_hit_p0 got %h exp %h", rd_hit_oh_o, 12'h008); end
        checks++; if (mem_rd_tag_o !== 20'hAAAA0) begin errors++; $display("FAIL b2b_tag_p0 got %h exp %h", mem_rd_tag_o, 20'hAAAA0); end
        @(posedge clk_i); #1;
        rd_req_i        = 3'b000;
        mem_rd_hit_oh_i = 4'b0100;
        #1;
        checks++; if (rd_hit_oh_o !== 12'h400) begin errors++; $display("FAIL b2b_hit_p2 got %h exp %h", rd_hit_oh_o, 12'h400); end
        checks++; if (mem_rd_tag_o !== 20'hCCCC2) begin errors++; $display("FAIL b2b_tag_p2 got %h exp %h", mem_rd_tag_o, 20'hCCCC2); end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk_i); #1;
        rd_req_i = 3'b010;
        #1;
        checks++; if (rd_ack_o !== 3'b010) begin errors++; $display("FAIL mid_ack got %b exp %b", rd_ack_o, 3'b010); end
        @(posedge clk_i); #1;
        rd_req_i        = 3'b000;
        mem_rd_hit_oh_i = 4'b0100;
        #1;
        checks++; if (rd_hit_oh_o !== 12'h040) begin errors++; $display("FAIL mid_hit_pre got %h exp %h", rd_hit_oh_o, 12'h040); end
        rst_ni = 1'b0;
        #1;
        checks++; if (rd_hit_oh_o !== 12'h000) begin errors++; $display("FAIL mid_hit_rst got %h exp %h", rd_hit_oh_o, 12'h000); end
        checks++; if (mem_rd_tag_o !== 20'hAAAA0) begin errors++; $display("FAIL mid_tag_rst got %h exp %h", mem_rd_tag_o, 20'hAAAA0); end
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        rd_req_i = 3'b110;
        #1;
        checks++; if (rd_ack_o !== 3'b010) begin errors++; $display("FAIL mid_first_ack got %b exp %b", rd_ack_o, 3'b010); end
        checks++; if (mem_rd_idx_o !== 8'h41) begin errors++; $display("FAIL mid_first_idx got %h exp %h", mem_rd_idx_o, 8'h41); end
        @(posedge clk_i); #1;
        rd_req_i = 3'b000;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_mem_busy();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
